z80_mem_arbiter: RTL
====================

Name: z80_mem_arbiter

Overview:
Shares the single-port synchronous 1 KB system RAM between the tv80 CPU bus and one DMA requester, such as the planned UART boot loader.
It sits between the CPU bus pins (mreq_n/rd_n/wr_n/A/do/di/wait_n) and the memory block. It stalls the CPU via wait_n while DMA owns the RAM.
Arbitration uses a bounded DMA burst credit, so neither side starves. It also exports a CPU stall-cycle counter for profiling.

Parameters:
ADDR_W, 10, RAM address width; CPU address is truncated to ADDR_W bits, so addresses alias.
DMA_BURST, 4, max consecutive DMA grants while the CPU is also pending; must be at least 1.
STALL_W, 16, width of the stall counter.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
cpu_addr  in  16  CPU address bus
cpu_dout  in  8  CPU write data
cpu_mreq_n  in  1  CPU memory request, active low
cpu_rd_n  in  1  CPU read strobe, active low
cpu_wr_n  in  1  CPU write strobe, active low
cpu_din  out  8  read data to CPU, registered
cpu_wait_n  out  1  CPU wait, active low
dma_req  in  1  DMA request level
dma_we  in  1  1 = write, 0 = read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  8  DMA write data
dma_gnt  out  1  one-cycle pulse: access issued to RAM
dma_ack  out  1  one-cycle pulse: access complete, dma_rdata valid
dma_rdata  out  8  DMA read data, held until next ack
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_din  out  8  RAM write data
mem_dout  in  8  RAM read data, 1-cycle latency from mem_addr
stall_cnt  out  STALL_W  saturating count of cycles with cpu_wait_n = 0

Behaviour:
- cpu_pend = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n).
- FSM states:
  - IDLE: arbitrate.
  - CPU_ACC: CPU owns RAM.
  - DMA_ACC: one cycle, dma_gnt = 1.
  - DMA_RSP: one cycle, dma_ack = 1; arbitrates again.
- Arbitration (IDLE and DMA_RSP):
  - Only cpu_pend -> CPU_ACC.
  - Only dma_req -> DMA_ACC.
  - Both pending: DMA_ACC if dma_streak < DMA_BURST, else CPU_ACC.
  - Neither -> IDLE.
  - dma_streak increments (saturating) on each DMA grant and clears on each CPU grant.
- CPU_ACC:
  - mem_addr = cpu_addr[ADDR_W-1:0]; mem_din = cpu_dout.
  - mem_we = 1 only on the first CPU_ACC cycle, and only if !cpu_wr_n: exactly one write per CPU cycle.
  - cpu_din <= mem_dout every cycle in CPU_ACC from the second cycle on. Read data is therefore valid 2 clocks after entry.
  - Exit to IDLE when cpu_pend deasserts.
- DMA_ACC:
  - mem_addr = dma_addr; mem_din = dma_wdata; mem_we = dma_we; dma_gnt = 1.
  - Always proceeds to DMA_RSP.
- DMA_RSP:
  - dma_ack = 1; dma_rdata <= mem_dout, captured at the end of this cycle.
  - For writes, dma_rdata is also updated and its value is don't-care.
- Outside CPU_ACC/DMA_ACC, mem_we = 0 and mem_addr holds its last value.
- cpu_wait_n = !(cpu_pend && state != CPU_ACC), combinational; forced to 1 while reset is high.
- DMA handshake:
  - Requester holds dma_req, dma_we, dma_addr and dma_wdata stable from request until dma_ack.
  - Dropping dma_req before dma_gnt withdraws the request.
  - After dma_gnt the access always completes with dma_ack.
  - dma_req still high in the ack cycle is treated as a new request.
- Minimum DMA throughput: 1 access per 2 clocks when the CPU is idle.
- stall_cnt increments on each clock with cpu_wait_n = 0 and saturates at all-ones; no wrap.
- Reset (asynchronous, at any time, including mid-access):
  - State -> IDLE.
  - dma_gnt, dma_ack, mem_we = 0; cpu_din, dma_rdata, mem_addr, mem_din = 0.
  - dma_streak = 0; stall_cnt = 0.
  - An in-flight DMA access is abandoned with no ack; the requester must reissue.

Decomposition:
- Shared package z80_mem_pkg: state enum (IDLE, CPU_ACC, DMA_ACC, DMA_RSP), default ADDR_W = 10, default STALL_W = 16.
- One natural sub-module: sat_counter (parameterised width, inc, clear, async reset). Used for both dma_streak and stall_cnt.

Test Plan:
- CPU read only: cpu_pend at 0x0012, RAM[0x12] = 0xA5 -> CPU_ACC next clock, cpu_wait_n stays 1, cpu_din = 0xA5 two clocks after entry, no dma_gnt.
- CPU write: cpu_wr_n = 0, addr 0x0412, data 0x3C, held 3 clocks -> exactly one mem_we pulse with mem_addr = 0x012; later read of 0x012 returns 0x3C.
- DMA write then read, CPU idle: write 0x55 to 0x3FF, then read 0x3FF -> gnt/ack pulses 1 clock apart, dma_rdata = 0x55; back-to-back accesses at 2-clock spacing.
- Contention, DMA_BURST = 4: dma_req held high continuously and cpu_pend asserted in IDLE -> 4 DMA grants, then CPU_ACC. stall_cnt equals the cycles cpu_wait_n was low (9 from the cycle cpu_pend rose).
- DMA withdraw: dma_req high 0 clocks before a CPU grant, then dropped while CPU_ACC is active -> no dma_gnt, no dma_ack.
- Reset mid-access: assert reset during DMA_ACC -> dma_gnt drops immediately, no dma_ack, all outputs at reset values, stall_cnt = 0; normal operation after release.

Source files
------------

// File: rtl/z80_mem_pkg.sv
// Shared definitions for the tv80 system RAM arbiter.
// Holds the arbiter state encoding and the default bus widths.
package z80_mem_pkg;

   localparam int DEF_ADDR_W  = 10;
   localparam int DEF_STALL_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      CPU_ACC,
      DMA_ACC,
      DMA_RSP
   } arb_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
// The count holds at all-ones instead of wrapping to zero.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/z80_mem_arbiter.sv
// Shares the single-port synchronous system RAM between the tv80 CPU bus and one DMA requester.
// The CPU is stalled through cpu_wait_n while DMA owns the RAM; DMA bursts are bounded by a credit.
module z80_mem_arbiter
   import z80_mem_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DMA_BURST = 4,
   parameter int STALL_W   = DEF_STALL_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [15:0]        cpu_addr,
   input  logic [7:0]         cpu_dout,
   input  logic               cpu_mreq_n,
   input  logic               cpu_rd_n,
   input  logic               cpu_wr_n,
   output logic [7:0]         cpu_din,
   output logic               cpu_wait_n,
   input  logic               dma_req,
   input  logic               dma_we,
   input  logic [ADDR_W-1:0]  dma_addr,
   input  logic [7:0]         dma_wdata,
   output logic               dma_gnt,
   output logic               dma_ack,
   output logic [7:0]         dma_rdata,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [7:0]         mem_din,
   input  logic [7:0]         mem_dout,
   output logic [STALL_W-1:0] stall_cnt
);

   localparam int STREAK_W = $clog2(DMA_BURST + 1);
   localparam logic [STREAK_W-1:0] BURST_LIM = STREAK_W'(DMA_BURST);

   arb_state_e          state_q;
   arb_state_e          state_d;
   logic                cpu_pend;
   logic                cpu_first_q;
   logic                grant_cpu;
   logic                grant_dma;
   logic                dma_credit;
   logic [STREAK_W-1:0] dma_streak;
   logic [ADDR_W-1:0]   addr_hold_q;
   logic [7:0]          din_hold_q;
   logic                addr_hi_unused;

   // RAM is smaller than the CPU space; the upper address bits simply alias.
   assign addr_hi_unused = ^cpu_addr[15:ADDR_W];

   assign cpu_pend   = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);
   assign dma_credit = (dma_streak < BURST_LIM);
   assign cpu_wait_n = reset || !(cpu_pend && (state_q != CPU_ACC));

   always_comb begin
      state_d   = state_q;
      grant_cpu = 1'b0;
      grant_dma = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = addr_hold_q;
      mem_din   = din_hold_q;
      dma_gnt   = 1'b0;
      dma_ack   = 1'b0;
      case (state_q)
         IDLE, DMA_RSP: begin
            dma_ack = (state_q == DMA_RSP);
            if (cpu_pend && (!dma_req || !dma_credit)) begin
               state_d   = CPU_ACC;
               grant_cpu = 1'b1;
            end else if (dma_req) begin
               state_d   = DMA_ACC;
               grant_dma = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         CPU_ACC: begin
            mem_addr = cpu_addr[ADDR_W-1:0];
            mem_din  = cpu_dout;
            // Only the first cycle writes, so a long wr_n strobe stores once.
            mem_we   = cpu_first_q && !cpu_wr_n;
            if (!cpu_pend) begin
               state_d = IDLE;
            end
         end
         DMA_ACC: begin
            mem_addr = dma_addr;
            mem_din  = dma_wdata;
            mem_we   = dma_we;
            dma_gnt  = 1'b1;
            state_d  = DMA_RSP;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cpu_first_q <= 1'b0;
         addr_hold_q <= '0;
         din_hold_q  <= '0;
         cpu_din     <= '0;
         dma_rdata   <= '0;
      end else begin
         state_q     <= state_d;
         cpu_first_q <= grant_cpu;
         addr_hold_q <= mem_addr;
         din_hold_q  <= mem_din;
         // RAM output lags the address by one clock, so skip the entry cycle.
         if ((state_q == CPU_ACC) && !cpu_first_q) begin
            cpu_din <= mem_dout;
         end
         if (state_q == DMA_RSP) begin
            dma_rdata <= mem_dout;
         end
      end
   end

   sat_counter #(
      .WIDTH (STREAK_W)
   ) u_streak (
      .clk   (clk),
      .reset (reset),
      .inc   (grant_dma),
      .clear (grant_cpu),
      .count (dma_streak)
   );

   sat_counter #(
      .WIDTH (STALL_W)
   ) u_stall (
      .clk   (clk),
      .reset (reset),
      .inc   (!cpu_wait_n),
      .clear (1'b0),
      .count (stall_cnt)
   );

endmodule
